// File: rtl/pairing_job_scheduler_pkg.sv
// Shared definitions for the pairing job scheduler: operand widths, FSM encoding
// and a constant-friendly ceiling-log2 helper.
package pairing_job_scheduler_pkg;

  localparam int WIDTH = 15;
  localparam int W6    = 6 * WIDTH + 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/pairing_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// wrapping, and returns both a one-hot grant and its encoded index.
module rr_arbiter
  import pairing_job_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic found_s;
  logic hit_s;
  int   idx_s;

  // Scan requesters starting from the pointer, first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    idx_s    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s        = (int'(ptr) + i) % NREQ;
      hit_s        = !found_s && req[idx_s];
      grant[idx_s] = hit_s;
      grant_id     = hit_s ? IDW'(idx_s) : grant_id;
      found_s      = found_s | hit_s;
    end
    grant_any = found_s;
  end

endmodule

// File: rtl/pairing_job_scheduler.sv
// Front-end scheduler for one tate_pairing core: round-robin job intake,
// core reset/run sequencing, watchdog abort and tagged response hand-back.
module pairing_job_scheduler
  import pairing_job_scheduler_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_x1,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_y1,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_x2,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_y2,
  output logic                        core_reset,
  output logic [WIDTH:0]              core_x1,
  output logic [WIDTH:0]              core_y1,
  output logic [WIDTH:0]              core_x2,
  output logic [WIDTH:0]              core_y2,
  input  logic                        core_done,
  input  logic [W6:0]                 core_out,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [clog2(NREQ)-1:0]      rsp_id,
  output logic [W6:0]                 rsp_data,
  output logic                        rsp_err,
  output logic                        busy
);

  localparam int IDW = clog2(NREQ);
  localparam int OPW = WIDTH + 1;
  localparam int LCW = clog2(RST_CYCLES + 1);
  localparam int WDW = clog2(TIMEOUT + 1);

  state_e          state_r;
  state_e          state_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [LCW-1:0]  lc_r;
  logic [WDW-1:0]  wd_r;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            grant_any_s;
  logic            timeout_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_id  (grant_id_s),
    .grant_any (grant_any_s)
  );

  assign timeout_s = (wd_r == WDW'(TIMEOUT));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a done on the timeout cycle still counts as done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_any_s) begin
          state_s = S_LAUNCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (lc_r == LCW'(RST_CYCLES)) begin
          state_s = S_RUN;
        end else begin
          state_s = S_LAUNCH;
        end
      end
      S_RUN: begin
        if (core_done || timeout_s) begin
          state_s = S_RESP;
        end else begin
          state_s = S_RUN;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs; the core is parked in reset whenever no job is running.
  always_comb begin
    req_ready  = (!reset && state_r == S_IDLE) ? grant_s : '0;
    core_reset = reset || state_r == S_IDLE || state_r == S_LAUNCH;
    busy       = !reset && state_r != S_IDLE;
  end

  // Job datapath: operand latch, pointer, launch/watchdog counters, response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r  <= '0;
      lc_r      <= '0;
      wd_r      <= '0;
      core_x1   <= '0;
      core_y1   <= '0;
      core_x2   <= '0;
      core_y2   <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_any_s) begin
            core_x1  <= req_x1[int'(grant_id_s)*OPW +: OPW];
            core_y1  <= req_y1[int'(grant_id_s)*OPW +: OPW];
            core_x2  <= req_x2[int'(grant_id_s)*OPW +: OPW];
            core_y2  <= req_y2[int'(grant_id_s)*OPW +: OPW];
            rsp_id   <= grant_id_s;
            rr_ptr_r <= (grant_id_s == IDW'(NREQ - 1)) ? IDW'(0) : grant_id_s + IDW'(1);
            lc_r     <= LCW'(1);
          end
        end
        S_LAUNCH: begin
          lc_r <= lc_r + LCW'(1);
          wd_r <= WDW'(1);
        end
        S_RUN: begin
          wd_r <= wd_r + WDW'(1);
          if (core_done) begin
            rsp_data  <= core_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (timeout_s) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_job_scheduler.sv
// Self-checking bench: core stub, table of directed jobs, reset-mid-job
// sequence and a randomized phase against a transaction-timing model.
module tb_pairing_job_scheduler;
  import pairing_job_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int RST  = 2;
  localparam int TMO  = 30;
  localparam int OPW  = WIDTH + 1;
  localparam int RW   = W6 + 1;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_x1, req_y1, req_x2, req_y2;
  logic                 core_reset;
  logic [OPW-1:0]       core_x1, core_y1, core_x2, core_y2;
  logic                 core_done;
  logic [RW-1:0]        core_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [RW-1:0]        rsp_data;
  logic                 rsp_err;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;
  int stub_lat = 0;
  int run_cnt  = 0;
  logic [OPW-1:0] xa [NREQ];
  logic [OPW-1:0] ya [NREQ];
  logic [OPW-1:0] xb [NREQ];
  logic [OPW-1:0] yb [NREQ];

  pairing_job_scheduler #(
    .NREQ       (NREQ),
    .RST_CYCLES (RST),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x1     (req_x1),
    .req_y1     (req_y1),
    .req_x2     (req_x2),
    .req_y2     (req_y2),
    .core_reset (core_reset),
    .core_x1    (core_x1),
    .core_y1    (core_y1),
    .core_x2    (core_x2),
    .core_y2    (core_y2),
    .core_done  (core_done),
    .core_out   (core_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] fold(input logic [OPW-1:0] a, b, c, d);
    return RW'({a ^ b ^ c ^ d, a, b, c, d});
  endfunction

  // Core stub: done on the stub_lat-th cycle out of reset (0 = never).
  always @(posedge clk) begin
    if (core_reset) run_cnt <= 0;
    else            run_cnt <= run_cnt + 1;
  end
  assign core_done = !core_reset && stub_lat != 0 && run_cnt == stub_lat - 1;
  assign core_out  = fold(core_x1, core_y1, core_x2, core_y2);

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < NREQ; k++) begin
      xa[k] = OPW'($urandom);
      ya[k] = OPW'($urandom);
      xb[k] = OPW'($urandom);
      yb[k] = OPW'($urandom);
      req_x1[k*OPW +: OPW] = xa[k];
      req_y1[k*OPW +: OPW] = ya[k];
      req_x2[k*OPW +: OPW] = xb[k];
      req_y2[k*OPW +: OPW] = yb[k];
    end
  endtask

  // One job: grant must appear on the first sample, response after exp_cyc.
  task automatic run_job(input logic [3:0] req, input int lat, input int exp_id,
                         input logic exp_err, input int exp_cyc, input int hold);
    logic [OPW-1:0] ex1, ey1, ex2, ey2;
    logic [RW-1:0]  edata;
    int n;
    logic got;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = req;
    stub_lat  = lat;
    drive_ops();
    #1;
    chk("idle_busy", RW'(busy), RW'(0));
    chk("idle_core_reset", RW'(core_reset), RW'(1));
    chk("grant", RW'(req_ready), RW'(4'b0001 << exp_id));
    ex1 = xa[exp_id]; ey1 = ya[exp_id]; ex2 = xb[exp_id]; ey2 = yb[exp_id];
    edata = exp_err ? RW'(0) : fold(ex1, ey1, ex2, ey2);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      drive_ops();
      #1;
      n++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        chk("job_core_reset", RW'(core_reset), RW'(n <= RST));
        chk("job_req_ready", RW'(req_ready), RW'(0));
      end
    end
    chk("rsp_seen", RW'(got), RW'(1));
    chk("rsp_latency", RW'(n), RW'(exp_cyc));
    chk("rsp_id", RW'(rsp_id), RW'(exp_id));
    chk("rsp_err", RW'(rsp_err), RW'(exp_err));
    chk("rsp_data", rsp_data, edata);
    chk("core_x1_held", RW'(core_x1), RW'(ex1));
    chk("core_y2_held", RW'(core_y2), RW'(ey2));
    chk("resp_core_reset", RW'(core_reset), RW'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", RW'(rsp_valid), RW'(1));
      chk("bp_data", rsp_data, edata);
      chk("bp_id", RW'(rsp_id), RW'(exp_id));
      chk("bp_req_ready", RW'(req_ready), RW'(0));
    end
    rsp_ready = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    int         lat;
    int         exp_id;
    logic       exp_err;
    int         exp_cyc;
    int         hold;
  } job_t;

  job_t jobs [12];

  // Transaction-level model state for the random phase.
  logic           m_busy;
  int             m_ptr, m_acc, m_total, m_id;
  logic           m_err;
  logic [RW-1:0]  m_data;
  logic [OPW-1:0] m_x1;

  initial begin
    jobs[0]  = '{4'b1111, 20, 0, 1'b0, 23, 0};
    jobs[1]  = '{4'b1111, 20, 1, 1'b0, 23, 0};
    jobs[2]  = '{4'b1111, 20, 2, 1'b0, 23, 0};
    jobs[3]  = '{4'b1111, 20, 3, 1'b0, 23, 0};
    jobs[4]  = '{4'b1111, 20, 0, 1'b0, 23, 0};
    jobs[5]  = '{4'b0010, 20, 1, 1'b0, 23, 0};
    jobs[6]  = '{4'b0011, 15, 0, 1'b0, 18, 10};
    jobs[7]  = '{4'b1001, 25, 3, 1'b0, 28, 0};
    jobs[8]  = '{4'b1000, 0,  3, 1'b1, 33, 0};
    jobs[9]  = '{4'b0100, 30, 2, 1'b0, 33, 0};
    jobs[10] = '{4'b0101, 31, 0, 1'b1, 33, 0};
    jobs[11] = '{4'b1110, 1,  1, 1'b0, 4,  0};

    reset = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    drive_ops();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", RW'(req_ready), RW'(0));
    chk("rst_core_reset", RW'(core_reset), RW'(1));
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("rst_rsp_valid", RW'(rsp_valid), RW'(0));
    chk("rst_rsp_err", RW'(rsp_err), RW'(0));
    chk("rst_rsp_id", RW'(rsp_id), RW'(0));
    chk("rst_rsp_data", rsp_data, RW'(0));
    chk("rst_core_x1", RW'(core_x1), RW'(0));
    chk("rst_core_y2", RW'(core_y2), RW'(0));
    chk("rst_busy", RW'(busy), RW'(0));

    for (int j = 0; j < 12; j++) begin
      run_job(jobs[j].req, jobs[j].lat, jobs[j].exp_id, jobs[j].exp_err,
              jobs[j].exp_cyc, jobs[j].hold);
    end

    // Reset in RUN cycle 5 of a job for requester 2 (pointer is at 2 here).
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    stub_lat  = 20;
    #1;
    chk("mid_grant", RW'(req_ready), RW'(4'b0100));
    for (int i = 0; i < RST + 5; i++) @(negedge clk);
    req_valid = 4'b0000;
    reset = 1'b1;
    #1;
    chk("mid_core_reset", RW'(core_reset), RW'(1));
    chk("mid_busy", RW'(busy), RW'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("post_rst_valid", RW'(rsp_valid), RW'(0));
      chk("post_rst_core_reset", RW'(core_reset), RW'(1));
      chk("post_rst_busy", RW'(busy), RW'(0));
      @(negedge clk);
    end
    run_job(4'b1111, 20, 0, 1'b0, 23, 0);
    run_job(4'b1000, 20, 3, 1'b0, 23, 0);

    // Random phase against the timing model, from a fresh reset.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_busy = 1'b0;
    m_ptr = 0; m_acc = 0; m_total = 0; m_id = 0;
    m_err = 1'b0; m_data = '0; m_x1 = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom);
      drive_ops();
      if (!m_busy) stub_lat = $urandom_range(0, 33);
      #1;
      if (!m_busy) begin
        int g;
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        end
        chk("r_grant", RW'(req_ready), (g < 0) ? RW'(0) : RW'(4'b0001 << g));
        chk("r_idle_busy", RW'(busy), RW'(0));
        chk("r_idle_core_reset", RW'(core_reset), RW'(1));
        chk("r_idle_valid", RW'(rsp_valid), RW'(0));
        if (g >= 0) begin
          m_busy  = 1'b1;
          m_acc   = cyc;
          m_id    = g;
          m_err   = !(stub_lat != 0 && stub_lat <= TMO);
          m_total = RST + (m_err ? TMO : stub_lat) + 1;
          m_data  = m_err ? RW'(0) : fold(xa[g], ya[g], xb[g], yb[g]);
          m_x1    = xa[g];
          m_ptr   = (g + 1) % NREQ;
        end
      end else begin
        int n;
        n = cyc - m_acc;
        chk("r_req_ready", RW'(req_ready), RW'(0));
        chk("r_busy", RW'(busy), RW'(1));
        chk("r_core_reset", RW'(core_reset), RW'(n <= RST));
        chk("r_core_x1", RW'(core_x1), RW'(m_x1));
        chk("r_valid", RW'(rsp_valid), RW'(n >= m_total));
        if (n >= m_total) begin
          chk("r_id", RW'(rsp_id), RW'(m_id));
          chk("r_err", RW'(rsp_err), RW'(m_err));
          chk("r_data", rsp_data, m_data);
          if (rsp_ready) m_busy = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks done", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pairing_job_scheduler.md
# pairing_job_scheduler

Front-end scheduler for a single `tate_pairing` core. It arbitrates round-robin between `NREQ` requesters and latches the winner's operand set. It then sequences the core through its reset/run protocol and returns the result, tagged with the requester index. A watchdog aborts hung jobs. The block sits between the system bus adapters and the pairing core, and it is the only driver of the core's `reset` and operand inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `RST_CYCLES`, 2: cycles `core_reset` is held high at job launch, minimum 2.
- `TIMEOUT`, 65535: maximum cycles allowed in RUN before abort.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in `NREQ`: per-requester job request.
- `req_ready` out `NREQ`: one-hot grant/accept, 0 outside IDLE.
- `req_x1`, `req_y1`, `req_x2`, `req_y2` in `NREQ*(WIDTH+1)` each: packed operands, slice k belongs to requester k.
- `core_reset` out 1: drives the core's `reset`.
- `core_x1`, `core_y1`, `core_x2`, `core_y2` out `WIDTH+1`: latched operands to the core.
- `core_done` in 1: core `done`.
- `core_out` in `W6+1`: core `out`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out `clog2(NREQ)`: requester index of the response.
- `rsp_data` out `W6+1`: pairing result, 0 when `rsp_err`.
- `rsp_err` out 1: job aborted by the watchdog.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - Grant is combinational: the first `req_valid` bit at or after `rr_ptr`, wrapping.
  - `req_ready` is the one-hot grant.
  - On a grant, latch that requester's four operands into `core_*`, store the id, move `rr_ptr` to (id+1) mod `NREQ`, and go to LAUNCH.
- LAUNCH:
  - `core_reset` is 1.
  - A counter runs for `RST_CYCLES` cycles, then the block goes to RUN.
- RUN:
  - `core_reset` is 0 and the watchdog counts up.
  - On the first cycle with `core_done`=1: capture `rsp_data`=`core_out` and set `rsp_err`=0.
  - Watchdog reaches `TIMEOUT` with no done: set `rsp_data`=0 and `rsp_err`=1.
  - Either way, set `rsp_valid`=1 and go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid` holds and `rsp_*` are stable until `rsp_ready`.
  - On handshake, drop `rsp_valid`, assert `core_reset`, and return to IDLE.
- `core_reset` is 1 in IDLE and LAUNCH and on RESP exit. It is 0 only in RUN and RESP. This parks the core.
- `core_*` operands stay constant from LAUNCH through RESP. The core samples the x2/y2 operands combinationally throughout the run.
- A requester that drops `req_valid` while not granted loses nothing; there is no request queue.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0.
  - `core_reset`=1, `req_ready`=0 during the reset cycle, `rsp_valid`=0, `rsp_err`=0.
  - `rsp_id`=0, `rsp_data`=0, `core_*`=0, `busy`=0.
- Accept happens in cycle A (`req_valid[k]` & `req_ready[k]`).
  - `core_reset` stays 1 for cycles A+1 .. A+`RST_CYCLES`.
  - RUN starts at A+`RST_CYCLES`+1.
- `rsp_valid` rises one cycle after the qualifying `core_done` or timeout cycle.
- A new grant is possible at the earliest one cycle after the `rsp` handshake.
- Watchdog: RUN cycle count starts at 1 on entry. The timeout fires on the cycle the count equals `TIMEOUT`.
- `reset` mid-job: immediate return to reset values. Any pending response is discarded.

## Structure
- Shared package/include: existing `inc.v` `WIDTH`/`W6`, plus state encodings and the `clog2` function.
- One natural sub-module: `rr_arbiter` (`NREQ` request vector plus pointer in, one-hot grant plus encoded id out), purely combinational.

## Test plan
- The bench uses a core stub with `done` 20 cycles after `reset` falls and out = {x1,y1,x2,y2} folded by XOR.
- **Single request:**
  - Stimulus: `req_valid`=4'b0010, x1=3.
  - Required: `core_reset` high 2 cycles after accept, `rsp_id`=1, `rsp_data` matches the stub, `rsp_err`=0, `rsp_valid` 23 cycles after accept.
- **All four requesting continuously:**
  - Required: grant order 0,1,2,3,0.
  - Required: `rr_ptr` wraps and no requester is starved.
- **Backpressure:**
  - Stimulus: `rsp_ready`=0 for 10 cycles.
  - Required: `rsp_*` stable, `req_ready`=0 throughout, next grant 1 cycle after the handshake.
- **Timeout:**
  - Stimulus: `TIMEOUT`=30, stub never asserts done.
  - Required: `rsp_err`=1, `rsp_data`=0, `rsp_valid` one cycle after RUN cycle 30.
- **Done on the timeout cycle** (stub latency equals `TIMEOUT`):
  - Required: `rsp_err`=0 with valid data.
- **`reset` asserted in RUN cycle 5:**
  - Required: `rsp_valid` never rises, `core_reset`=1, `busy`=0.
  - Required: after reset, `req_valid`=4'b1000 is granted to id 3 (pointer restarts at 0).
